// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared types for the SPI master core.
//   state_t    - FSM state encoding
//   spi_mode_t - per-transfer mode bits latched at accept
package spi_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: handshake, configuration and SPI pin bundle of spi_master_core.
//   master modport - seen by the core (drives tx_ready, rx_*, busy, sclk, mosi, cs_n)
//   slave modport  - seen by the user logic / pin mapping (drives tx_*, config, miso)
interface spi_master_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int NUM_CS = 2
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic [CS_W-1:0]   cs_sel;
  logic [DIV_W-1:0]  clk_div;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_CS-1:0] cs_n;

  modport master (
    input  tx_data, tx_valid, cpol, cpha, lsb_first, cs_sel, clk_div, miso,
    output tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
  );

  modport slave (
    output tx_data, tx_valid, cpol, cpha, lsb_first, cs_sel, clk_div, miso,
    input  tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_core_clk_gen.sv
// spi_clk_gen: half-period timer for the SPI master.
//   clk, rst_n - system clock, synchronous active-low reset
//   i_en       - run the timer; while low the counter is held at i_div
//   i_div      - half-period minus one (H-1)
//   o_tick     - one-cycle pulse at the end of every H-cycle phase
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);
  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || (r_cnt == '0)) begin
      r_cnt <= i_div;
    end else begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == '0);
endmodule

// File: rtl/spi_master_core.sv
// spi_master_core: parametrised SPI master, one word per ready/valid transfer.
//   clk, rst_n - system clock, synchronous active-low reset
//   bus        - spi_master_if.master: tx handshake, per-transfer config,
//                rx word/pulse, busy, and the sclk/mosi/miso/cs_n pins
//
// state | meaning
// IDLE  | tx_ready high, sclk follows cpol, waiting for tx_valid
// SETUP | cs asserted, one half-period before the first sclk edge
// XFER  | 2*DATA_W sclk edges, one per half-period
// HOLD  | one half-period with sclk idle and cs still asserted
module spi_master_core
  import spi_master_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int NUM_CS = 2
) (
  input logic          clk,
  input logic          rst_n,
  spi_master_if.master bus
);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  state_t            r_state;
  spi_mode_t         r_mode;
  logic [DIV_W-1:0]  r_div;
  logic [EDGE_W-1:0] r_edge;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_busy;
  logic              r_sclk;
  logic              r_mosi;
  logic [NUM_CS-1:0] r_cs_n;

  logic              w_tick;
  logic [DIV_W-1:0]  w_div;
  logic [NUM_CS-1:0] w_cs_dec;
  logic              w_lead;
  logic              w_sample;
  logic              w_shift;
  logic              w_tx_bit;
  logic [DATA_W-1:0] w_tx_next;
  logic [DATA_W-1:0] w_rx_next;

  // In IDLE the timer preloads from the live input so SETUP starts with
  // the divider captured on the accept edge.
  assign w_div = (r_state == IDLE) ? bus.clk_div : r_div;

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_state != IDLE),
    .i_div  (w_div),
    .o_tick (w_tick)
  );

  // Out-of-range cs_sel leaves every select deasserted.
  always_comb begin
    w_cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(bus.cs_sel) == i) w_cs_dec[i] = 1'b0;
    end
  end

  // r_edge counts edges already made, so even values mean the next edge leads.
  assign w_lead    = ~r_edge[0];
  assign w_sample  = r_mode.cpha ? ~w_lead : w_lead;
  assign w_shift   = r_mode.cpha ? w_lead : (~w_lead && (r_edge != LAST_EDGE));
  assign w_tx_bit  = r_mode.lsb_first ? r_tx[0] : r_tx[DATA_W-1];
  assign w_tx_next = r_mode.lsb_first ? (r_tx >> 1) : (r_tx << 1);
  assign w_rx_next = r_mode.lsb_first ? {bus.miso, r_rx[DATA_W-1:1]}
                                      : {r_rx[DATA_W-2:0], bus.miso};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mode     <= '0;
      r_div      <= '0;
      r_edge     <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= '1;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sclk <= bus.cpol;
          if (bus.tx_valid) begin
            r_mode.cpol      <= bus.cpol;
            r_mode.cpha      <= bus.cpha;
            r_mode.lsb_first <= bus.lsb_first;
            r_div            <= bus.clk_div;
            r_cs_n           <= w_cs_dec;
            r_edge           <= '0;
            r_busy           <= 1'b1;
            // CPHA=0 presents the first bit now; CPHA=1 waits for the first leading edge.
            if (bus.cpha) begin
              r_tx   <= bus.tx_data;
              r_mosi <= 1'b0;
            end else begin
              r_mosi <= bus.lsb_first ? bus.tx_data[0] : bus.tx_data[DATA_W-1];
              r_tx   <= bus.lsb_first ? (bus.tx_data >> 1) : (bus.tx_data << 1);
            end
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (w_tick) r_state <= XFER;
        end
        XFER: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + EDGE_W'(1);
            if (w_sample) r_rx <= w_rx_next;
            if (w_shift) begin
              r_mosi <= w_tx_bit;
              r_tx   <= w_tx_next;
            end
            if (r_edge == LAST_EDGE) r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_tick) begin
            r_state    <= IDLE;
            r_cs_n     <= '1;
            r_mosi     <= 1'b0;
            r_sclk     <= r_mode.cpol;
            r_rx_data  <= r_rx;
            r_rx_valid <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready = (r_state == IDLE);
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.busy     = r_busy;
  assign bus.sclk     = r_sclk;
  assign bus.mosi     = r_mosi;
  assign bus.cs_n     = r_cs_n;
endmodule

// File: tb/tb_spi_master_core.sv
// tb_spi_master_core: directed self-checking bench for spi_master_core.
module tb_spi_master_core;
  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  spi_master_if #(.DATA_W(8), .DIV_W(8), .NUM_CS(2)) bus ();
  spi_master_if #(.DATA_W(8), .DIV_W(8), .NUM_CS(3)) bus2 ();

  spi_master_core #(.DATA_W(8), .DIV_W(8), .NUM_CS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  spi_master_core #(.DATA_W(8), .DIV_W(8), .NUM_CS(3)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  // miso source: loopback from mosi or a mode-3-style slave shifting on leading edges
  logic       loop_en;
  logic       slave_miso;
  logic       slave_cpol;
  logic [7:0] slave_word;
  int         slave_bit;
  logic       prev_sclk;

  assign bus.miso  = loop_en ? bus.mosi : slave_miso;
  assign bus2.miso = bus2.mosi;

  initial begin
    slave_bit  = 7;
    prev_sclk  = 1'b0;
    slave_miso = 1'b0;
  end

  always @(negedge clk) begin
    if (bus.cs_n == 2'b11) begin
      slave_bit = 7;
    end else if ((bus.sclk != prev_sclk) && (bus.sclk != slave_cpol)) begin
      if (slave_bit >= 0) begin
        slave_miso = slave_word[slave_bit];
        slave_bit  = slave_bit - 1;
      end
    end
    prev_sclk = bus.sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a request in cycle t0 and returns at the negedge of cycle t0+1.
  logic cur_cpol;
  task automatic start_xfer(input logic [7:0] data, input logic cpol, input logic cpha,
                            input logic lsb, input logic cs, input logic [7:0] div,
                            input logic keep_valid, output int t0);
    @(negedge clk);
    bus.tx_data   = data;
    bus.cpol      = cpol;
    bus.cpha      = cpha;
    bus.lsb_first = lsb;
    bus.cs_sel    = cs;
    bus.clk_div   = div;
    bus.tx_valid  = 1'b1;
    cur_cpol      = cpol;
    t0            = cyc;
    @(negedge clk);
    if (!keep_valid) bus.tx_valid = 1'b0;
  endtask

  int st_cs0, st_cs1, st_rise, st_mosi_hi, st_first_mosi, st_first_rise, st_rv;

  // Samples each cycle until rx_valid (returns in that cycle) or budget expires.
  task automatic wait_done(input int budget);
    logic prev;
    st_cs0 = 0; st_cs1 = 0; st_rise = 0; st_mosi_hi = 0;
    st_first_mosi = -1; st_first_rise = -1; st_rv = -1;
    prev = cur_cpol;
    for (int i = 0; i < budget; i++) begin
      if (!bus.cs_n[0]) st_cs0++;
      if (!bus.cs_n[1]) st_cs1++;
      if (bus.sclk && !prev) begin
        st_rise++;
        if (st_first_rise < 0) st_first_rise = cyc;
      end
      if (bus.mosi) begin
        st_mosi_hi++;
        if (st_first_mosi < 0) st_first_mosi = cyc;
      end
      prev = bus.sclk;
      if (bus.rx_valid) begin
        st_rv = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int t0, t0b, rv_cnt, bad, rv2;
    n_tests = 0;
    n_fail  = 0;
    loop_en = 1'b1;
    slave_cpol = 1'b0;
    slave_word = 8'h00;
    cur_cpol = 1'b0;
    rst_n = 1'b0;
    bus.tx_data = '0; bus.tx_valid = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0;
    bus.lsb_first = 1'b0; bus.cs_sel = '0; bus.clk_div = '0;
    bus2.tx_data = '0; bus2.tx_valid = 1'b0; bus2.cpol = 1'b0; bus2.cpha = 1'b0;
    bus2.lsb_first = 1'b0; bus2.cs_sel = '0; bus2.clk_div = '0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_rx_data",  32'(bus.rx_data),  32'h00);
    chk("rst_sclk",     32'(bus.sclk),     32'd0);
    chk("rst_mosi",     32'(bus.mosi),     32'd0);
    chk("rst_cs_n",     32'(bus.cs_n),     32'b11);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // mode 0, H=1, loopback 0xA5
    start_xfer(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, t0);
    chk("m0_busy_t1",  32'(bus.busy),     32'd1);
    chk("m0_ready_t1", 32'(bus.tx_ready), 32'd0);
    wait_done(60);
    chk("m0_rv_cycle", 32'(st_rv - t0), 32'd19);
    chk("m0_rx_data",  32'(bus.rx_data), 32'hA5);
    chk("m0_cs0_low",  32'(st_cs0), 32'd18);
    chk("m0_cs1_low",  32'(st_cs1), 32'd0);
    chk("m0_rises",    32'(st_rise), 32'd8);
    chk("m0_done_ready", 32'({bus.tx_ready, bus.busy, bus.mosi}), 32'b100);
    @(negedge clk);
    chk("m0_rv_pulse", 32'(bus.rx_valid), 32'd0);

    // mode 3, clk_div=3, slave returns 0x3C on cs 1
    loop_en = 1'b0;
    slave_cpol = 1'b1;
    slave_word = 8'h3C;
    bus.cpol = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("m3_idle_sclk", 32'(bus.sclk), 32'd1);
    start_xfer(8'h96, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, t0);
    wait_done(200);
    chk("m3_rv_cycle", 32'(st_rv - t0), 32'd73);
    chk("m3_rx_data",  32'(bus.rx_data), 32'h3C);
    chk("m3_cs0_low",  32'(st_cs0), 32'd0);
    chk("m3_cs1_low",  32'(st_cs1), 32'd72);
    chk("m3_end_sclk", 32'(bus.sclk), 32'd1);
    loop_en = 1'b1;
    slave_cpol = 1'b0;

    // mode 1, lsb first, 0x01: mosi high for exactly the first bit window
    start_xfer(8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, t0);
    wait_done(60);
    chk("m1_first_rise", 32'(st_first_rise - t0), 32'd3);
    chk("m1_first_mosi", 32'(st_first_mosi - t0), 32'd3);
    chk("m1_mosi_hi",    32'(st_mosi_hi), 32'd2);
    chk("m1_rx_data",    32'(bus.rx_data), 32'h01);
    chk("m1_rv_cycle",   32'(st_rv - t0), 32'd19);

    // back-to-back with tx_valid held; second word presented after first accept
    start_xfer(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, t0);
    bus.tx_data = 8'h22;
    wait_done(60);
    chk("b2b_rv1_cycle", 32'(st_rv - t0), 32'd19);
    chk("b2b_rx1",       32'(bus.rx_data), 32'h11);
    chk("b2b_ready_rv",  32'(bus.tx_ready), 32'd1);
    chk("b2b_cs_high",   32'(bus.cs_n[0]), 32'd1);
    t0b = cyc;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("b2b_cs_relow",  32'(bus.cs_n[0]), 32'd0);
    chk("b2b_busy2",     32'(bus.busy), 32'd1);
    wait_done(60);
    chk("b2b_rv2_cycle", 32'(st_rv - t0b), 32'd19);
    chk("b2b_rx2",       32'(bus.rx_data), 32'h22);

    // reset in the middle of a transfer
    start_xfer(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, t0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_cs_n",  32'(bus.cs_n), 32'b11);
    chk("rstmid_sclk",  32'(bus.sclk), 32'd0);
    chk("rstmid_ready", 32'(bus.tx_ready), 32'd1);
    chk("rstmid_busy",  32'(bus.busy), 32'd0);
    rv_cnt = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (bus.rx_valid) rv_cnt++;
      @(negedge clk);
    end
    chk("rstmid_no_rv", 32'(rv_cnt), 32'd0);

    // out-of-range cs_sel on the 3-select instance
    @(negedge clk);
    bus2.tx_data = 8'h5A; bus2.cs_sel = 2'd3; bus2.clk_div = 8'd0; bus2.tx_valid = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus2.tx_valid = 1'b0;
    bad = 0;
    rv2 = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus2.cs_n != 3'b111) bad++;
      if (bus2.rx_valid) begin
        rv2 = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("oor_cs_n",     32'(bad), 32'd0);
    chk("oor_rv_cycle", 32'(rv2 - t0), 32'd19);
    chk("oor_rx_data",  32'(bus2.rx_data), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
